// File: rtl/vga_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_ctrl_pkg
//  Brief    : Shared types and constants for the VGA driver control logic.
//             Holds the level_pulse_gen state encoding and the default
//             synchroniser depth used by the async inputs.
//  Revision : 1.0  initial release
// ============================================================================
package vga_ctrl_pkg;

    // Default depth of the flop synchronisers on asynchronous inputs
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Debounce FSM: two stable states plus one confirm state per direction
    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } lpg_state_t;

endpackage : vga_ctrl_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ff
//  Brief    : N-stage flop synchroniser for a single asynchronous bit.
//             All stages clear to 0 on reset. Output is the last stage.
//  Revision : 1.0  initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/level_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : level_pulse_gen
//  Brief    : Synchronises and debounces one asynchronous level, producing a
//             registered debounced level plus one-cycle rise/fall pulses on
//             each confirmed edge. busy flags an edge under confirmation.
//  Revision : 1.0  initial release
// ============================================================================
module level_pulse_gen
    import vga_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    input  logic enable,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Count value at which the final confirming sample is taken
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             w_sync;

    lpg_state_t       r_state;
    lpg_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;
    logic             w_level_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_busy_nxt;

    // Synchroniser runs independently of enable so the sampled level is
    // always current when detection is re-enabled.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (level_in),
        .q     (w_sync)
    );

    // Next-state, counter and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            S_LOW: begin
                if (enable && w_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // Single-sample debounce: first sample confirms
                        w_state_nxt = S_HIGH;
                        w_level_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_RISE_CHK;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
            end

            S_RISE_CHK: begin
                if (!enable || !w_sync) begin
                    // Disabled or glitch: abandon the edge silently
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_HIGH;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (r_cnt < c_cnt_last) begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end

            S_HIGH: begin
                if (enable && !w_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = S_LOW;
                        w_level_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_FALL_CHK;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
            end

            S_FALL_CHK: begin
                if (!enable || w_sync) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_LOW;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (r_cnt < c_cnt_last) begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end

            default: begin
                w_state_nxt = S_LOW;
                w_cnt_nxt   = '0;
            end
        endcase

        // busy is registered from the next state so it tracks r_state exactly
        w_busy_nxt = (w_state_nxt == S_RISE_CHK) || (w_state_nxt == S_FALL_CHK);
    end

    // FSM state and debounce counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = r_busy;

endmodule : level_pulse_gen
`default_nettype wire
